// File: rtl/router_fsm_nch.sv
// router_fsm_nch: N-channel router controller FSM.
// Takes one packet at a time from the input port and steers it into one of
// NUM_CH output FIFOs. It decodes the header address, latches the target
// channel, and drives the router_reg and synchroniser control strobes.
// Every output is a Moore output, decoded only from state_q and cur_ch_q.
// Optional feature macro: ROUTER_FSM_DROP_EN. When it is defined, a packet
// whose address is out of range is consumed in DROP_PKT and never written.
module router_fsm_nch #(
    parameter int NUM_CH = 3,
    parameter int ADDR_W = 2
) (
    input  logic              clock,
    input  logic              resetn,
    input  logic              pkt_valid,
    input  logic              parity_done,
    input  logic              low_pkt_valid,
    input  logic              fifo_full,
    input  logic [NUM_CH-1:0] fifo_empty,
    input  logic [NUM_CH-1:0] soft_reset,
    input  logic [ADDR_W-1:0] data_in,
    output logic              detect_add,
    output logic              lfd_state,
    output logic              ld_state,
    output logic              laf_state,
    output logic              full_state,
    output logic              write_enb_reg,
    output logic              rst_int_reg,
    output logic              busy,
    output logic [NUM_CH-1:0] ch_sel,
    output logic              pkt_drop
);

    typedef enum logic [3:0] {
        ST_DA, ST_WTE, ST_LFD, ST_LD, ST_FFS, ST_LAF, ST_LP, ST_CPE
`ifdef ROUTER_FSM_DROP_EN
        , ST_DROP
`endif
    } state_e;

    localparam logic [ADDR_W:0] NUM_CH_W = (ADDR_W+1)'(NUM_CH);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] cur_ch_q, cur_ch_d;
    logic              addr_ok, empty_in, empty_cur, srst_cur;

    // Look up the per-channel flags for the incoming address and for the
    // latched channel. An address that is out of range matches no channel.
    always_comb begin
        addr_ok   = ({1'b0, data_in} < NUM_CH_W);
        empty_in  = 1'b0;
        empty_cur = 1'b0;
        srst_cur  = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (data_in == ADDR_W'(i)) empty_in = fifo_empty[i];
            if (cur_ch_q == ADDR_W'(i)) begin
                empty_cur = fifo_empty[i];
                srst_cur  = soft_reset[i];
            end
        end
    end

    // Next-state logic. A soft reset on the latched channel overrides every
    // other transition, but only while a packet is actually in flight.
    always_comb begin
        state_d  = state_q;
        cur_ch_d = cur_ch_q;
        if (state_q != ST_DA
`ifdef ROUTER_FSM_DROP_EN
            && state_q != ST_DROP
`endif
            && srst_cur) begin
            state_d = ST_DA;
        end else begin
            case (state_q)
                ST_DA: begin
                    if (pkt_valid && addr_ok) begin
                        cur_ch_d = data_in;
                        state_d  = empty_in ? ST_LFD : ST_WTE;
                    end
`ifdef ROUTER_FSM_DROP_EN
                    else if (pkt_valid) state_d = ST_DROP;
`endif
                end
                ST_WTE:  if (empty_cur) state_d = ST_LFD;
                ST_LFD:  state_d = ST_LD;
                ST_LD: begin
                    if (fifo_full)       state_d = ST_FFS;
                    else if (!pkt_valid) state_d = ST_LP;
                end
                ST_FFS:  if (!fifo_full) state_d = ST_LAF;
                ST_LAF: begin
                    if (parity_done)        state_d = ST_DA;
                    else if (low_pkt_valid) state_d = ST_LP;
                    else                    state_d = ST_LD;
                end
                ST_LP:   state_d = ST_CPE;
                ST_CPE:  state_d = fifo_full ? ST_FFS : ST_DA;
`ifdef ROUTER_FSM_DROP_EN
                ST_DROP: if (!pkt_valid) state_d = ST_DA;
`endif
                default: state_d = ST_DA;
            endcase
        end
    end

    // State and latched-channel registers.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q  <= ST_DA;
            cur_ch_q <= '0;
        end else begin
            state_q  <= state_d;
            cur_ch_q <= cur_ch_d;
        end
    end

`ifdef ROUTER_FSM_DROP_EN
    logic pkt_drop_q;
    // Pulse for one cycle when a dropped packet ends, in the cycle the
    // state is back in DA.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) pkt_drop_q <= 1'b0;
        else         pkt_drop_q <= (state_q == ST_DROP) && !pkt_valid;
    end
    assign pkt_drop = pkt_drop_q;
`else
    assign pkt_drop = 1'b0;
`endif

    // Moore output decode. ch_sel stays all-zero while no channel is owned.
    always_comb begin
        detect_add    = (state_q == ST_DA);
        lfd_state     = (state_q == ST_LFD);
        ld_state      = (state_q == ST_LD);
        laf_state     = (state_q == ST_LAF);
        full_state    = (state_q == ST_FFS);
        rst_int_reg   = (state_q == ST_CPE);
        write_enb_reg = (state_q == ST_LD) || (state_q == ST_LP) || (state_q == ST_LAF);
        busy          = (state_q == ST_LFD) || (state_q == ST_LP) || (state_q == ST_FFS) ||
                        (state_q == ST_LAF) || (state_q == ST_WTE) || (state_q == ST_CPE);
        ch_sel        = '0;
        if (state_q != ST_DA
`ifdef ROUTER_FSM_DROP_EN
            && state_q != ST_DROP
`endif
           ) begin
            for (int i = 0; i < NUM_CH; i++) ch_sel[i] = (cur_ch_q == ADDR_W'(i));
        end
    end

endmodule

// File: tb/tb_router_fsm_nch.sv
// Testbench for router_fsm_nch. It applies the directed scenarios first and
// then randomized traffic. Each cycle it checks the DUT against a reference
// model of the packet-sequencing rules.
module tb_router_fsm_nch;
    localparam int NUM_CH = 3;
    localparam int ADDR_W = 2;
    localparam int OW     = NUM_CH + 9;
    // reference-model phases
    localparam int DA = 0, WTE = 1, LFD = 2, LD = 3, FFS = 4, LAF = 5, LP = 6, CPE = 7, DRP = 8;

    logic              clock = 1'b0, resetn = 1'b0;
    logic              pkt_valid = 1'b0, parity_done = 1'b0, low_pkt_valid = 1'b0, fifo_full = 1'b0;
    logic [NUM_CH-1:0] fifo_empty = '0, soft_reset = '0;
    logic [ADDR_W-1:0] data_in = '0;
    logic              detect_add, lfd_state, ld_state, laf_state, full_state;
    logic              write_enb_reg, rst_int_reg, busy, pkt_drop;
    logic [NUM_CH-1:0] ch_sel;
    logic [OW-1:0]     obs;

    int vecs = 0, errs = 0;
    int ms = DA, mch = 0;
    bit mdrop = 1'b0;
`ifdef ROUTER_FSM_DROP_EN
    bit drop_en = 1'b1;
`else
    bit drop_en = 1'b0;
`endif

    always #5 clock = ~clock;

    router_fsm_nch #(.NUM_CH(NUM_CH), .ADDR_W(ADDR_W)) dut (
        .clock(clock), .resetn(resetn), .pkt_valid(pkt_valid), .parity_done(parity_done),
        .low_pkt_valid(low_pkt_valid), .fifo_full(fifo_full), .fifo_empty(fifo_empty),
        .soft_reset(soft_reset), .data_in(data_in), .detect_add(detect_add),
        .lfd_state(lfd_state), .ld_state(ld_state), .laf_state(laf_state),
        .full_state(full_state), .write_enb_reg(write_enb_reg), .rst_int_reg(rst_int_reg),
        .busy(busy), .ch_sel(ch_sel), .pkt_drop(pkt_drop)
    );

    assign obs = {detect_add, lfd_state, ld_state, laf_state, full_state,
                  write_enb_reg, rst_int_reg, busy, pkt_drop, ch_sel};

    function automatic logic [OW-1:0] model_out();
        logic [NUM_CH-1:0] cs;
        logic bz;
        cs = (ms == DA || ms == DRP) ? '0 : NUM_CH'(1 << mch);
        bz = (ms inside {LFD, LP, FFS, LAF, WTE, CPE});
        return {ms == DA, ms == LFD, ms == LD, ms == LAF, ms == FFS,
                ms inside {LD, LP, LAF}, ms == CPE, bz, mdrop, cs};
    endfunction

    // Advance the reference model by one clock using the current inputs.
    task automatic model_step();
        int ns;
        bit nd;
        ns = ms;
        nd = (ms == DRP) && !pkt_valid;
        if (ms != DA && ms != DRP && soft_reset[mch]) ns = DA;
        else case (ms)
            DA: if (pkt_valid) begin
                if (int'(data_in) < NUM_CH) begin
                    mch = int'(data_in);
                    ns  = fifo_empty[data_in] ? LFD : WTE;
                end else if (drop_en) ns = DRP;
            end
            WTE: if (fifo_empty[mch]) ns = LFD;
            LFD: ns = LD;
            LD:  ns = fifo_full ? FFS : (!pkt_valid ? LP : LD);
            FFS: if (!fifo_full) ns = LAF;
            LAF: ns = parity_done ? DA : (low_pkt_valid ? LP : LD);
            LP:  ns = CPE;
            CPE: ns = fifo_full ? FFS : DA;
            DRP: if (!pkt_valid) ns = DA;
            default: ns = DA;
        endcase
        ms = ns;
        mdrop = nd;
    endtask

    task automatic check(input string tag, input logic [OW-1:0] o, input logic [OW-1:0] e);
        vecs++;
        assert (o === e) else begin
            errs++;
            $error("FAIL %s observed=%h expected=%h", tag, o, e);
        end
    endtask

    task automatic drv(input bit pv, input int din, input logic [NUM_CH-1:0] fe,
                       input bit ff, input bit pd, input bit lpv, input logic [NUM_CH-1:0] sr);
        pkt_valid = pv; data_in = ADDR_W'(din); fifo_empty = fe; fifo_full = ff;
        parity_done = pd; low_pkt_valid = lpv; soft_reset = sr;
    endtask

    task automatic step(input string tag);
        @(posedge clock);
        model_step();
        #1;
        check(tag, obs, model_out());
    endtask

    initial begin
        // reset state
        #12;
        check("reset", obs, model_out());
        check("reset_const", obs, {1'b1, 8'b0, NUM_CH'(0)});
        @(negedge clock);
        resetn = 1'b1;

        // empty path on ch0
        drv(1, 0, 3'b111, 0, 0, 0, 0);
        step("ep_lfd");
        check("ep_lfd_sel", OW'({lfd_state, busy, ch_sel}), OW'({1'b1, 1'b1, 3'b001}));
        step("ep_ld");
        check("ep_wen", OW'({ld_state, write_enb_reg}), OW'(2'b11));
        step("ep_ld2");
        pkt_valid = 1'b0;
        step("ep_lp");
        step("ep_cpe");
        check("ep_rst_int", OW'(rst_int_reg), OW'(1));
        step("ep_da");

        // wait-till-empty then full on ch1
        drv(1, 1, 3'b101, 0, 0, 0, 0);
        step("wf_wte");
        check("wf_wte_busy", OW'({busy, ch_sel}), OW'({1'b1, 3'b010}));
        step("wf_wte2");
        fifo_empty = 3'b111;
        step("wf_lfd");
        step("wf_ld");
        fifo_full = 1'b1;
        step("wf_ffs");
        check("wf_full", OW'(full_state), OW'(1));
        fifo_full = 1'b0;
        step("wf_laf");
        check("wf_laf_c", OW'(laf_state), OW'(1));
        low_pkt_valid = 1'b1;
        step("wf_lp");
        low_pkt_valid = 1'b0; pkt_valid = 1'b0;
        step("wf_cpe");
        step("wf_da");

        // LAF loopback on ch2, then LAF exit on parity_done
        drv(1, 2, 3'b111, 0, 0, 0, 0);
        step("lb_lfd"); step("lb_ld");
        fifo_full = 1'b1; step("lb_ffs");
        fifo_full = 1'b0; step("lb_laf");
        step("lb_ld2");
        check("lb_ld_c", OW'({ld_state, ch_sel}), OW'({1'b1, 3'b100}));
        pkt_valid = 1'b0; step("lb_lp");
        step("lb_cpe"); step("lb_da");
        pkt_valid = 1'b1;
        step("lb2_lfd"); step("lb2_ld");
        fifo_full = 1'b1; step("lb2_ffs");
        fifo_full = 1'b0; step("lb2_laf");
        parity_done = 1'b1; pkt_valid = 1'b0; step("lb2_da");
        check("lb2_da_c", OW'(detect_add), OW'(1));
        parity_done = 1'b0;

        // soft reset on the owned channel only
        drv(1, 2, 3'b011, 0, 0, 0, 0);
        step("sr_wte");
        soft_reset = 3'b001; step("sr_other");
        check("sr_other_c", OW'({busy, detect_add}), OW'(2'b10));
        soft_reset = 3'b100; step("sr_hit");
        check("sr_hit_c", OW'({busy, detect_add}), OW'(2'b01));
        drv(0, 0, 3'b111, 0, 0, 0, 0);
        step("sr_idle");

        // invalid address, four bytes then idle
        drv(1, 3, 3'b111, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) begin
            step("inv_pkt");
            check("inv_quiet", OW'({busy, write_enb_reg, ch_sel}), OW'(0));
        end
        pkt_valid = 1'b0;
        step("inv_end");
        check("inv_drop", OW'(pkt_drop), OW'(drop_en));
        step("inv_after");
        check("inv_drop_off", OW'(pkt_drop), OW'(0));

        // async reset in the middle of a packet
        drv(1, 0, 3'b111, 0, 0, 0, 0);
        step("ar_lfd"); step("ar_ld");
        resetn = 1'b0;
        #1;
        ms = DA; mch = 0; mdrop = 1'b0;
        check("ar_async", obs, {1'b1, 8'b0, NUM_CH'(0)});
        #2;
        resetn = 1'b1;
        pkt_valid = 1'b0;
        step("ar_idle");

        // randomized traffic
        for (int n = 0; n < 3000; n++) begin
            drv($urandom_range(0, 3) != 0, int'($urandom_range(0, 3)), NUM_CH'($urandom),
                $urandom_range(0, 3) == 0, $urandom_range(0, 7) == 0, $urandom_range(0, 3) == 0,
                ($urandom_range(0, 15) == 0) ? NUM_CH'($urandom) : '0);
            step("rand");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule

// File: doc/router_fsm_nch.md
Name: router_fsm_nch

Overview:
Parametrised successor to the 1x3 router controller FSM. It sequences one packet at a time from the input port into one of NUM_CH output FIFOs.
- Decodes the header address.
- Latches the target channel.
- Drives the register/synchroniser control strobes.
- Adds per-channel vectors, one-hot channel select and optional invalid-address packet dropping.
It sits between the input port, router_reg and the channel synchroniser/FIFOs.

Parameters:
NUM_CH, 3, number of output channels/FIFOs (2..2**ADDR_W)
ADDR_W, 2, header address field width; address = data_in[ADDR_W-1:0]

Ports:
clock  input  1  single system clock; all state on rising edge
resetn  input  1  asynchronous, active-low reset
pkt_valid  input  1  input packet byte valid
parity_done  input  1  parity byte captured by router_reg
low_pkt_valid  input  1  pkt_valid fell while FIFO was full (from router_reg)
fifo_full  input  1  full flag of currently selected FIFO (from synchroniser)
fifo_empty  input  NUM_CH  per-channel FIFO empty flags
soft_reset  input  NUM_CH  per-channel soft reset (read-timeout) pulses
data_in  input  ADDR_W  address bits of header byte
detect_add  output  1  state == DECODE_ADDRESS
lfd_state  output  1  state == LOAD_FIRST_DATA
ld_state  output  1  state == LOAD_DATA
laf_state  output  1  state == LOAD_AFTER_FULL
full_state  output  1  state == FIFO_FULL_STATE
write_enb_reg  output  1  LOAD_DATA | LOAD_PARITY | LOAD_AFTER_FULL
rst_int_reg  output  1  state == CHECK_PARITY_ERROR
busy  output  1  input port stall
ch_sel  output  NUM_CH  one-hot latched channel; all-zero in DECODE_ADDRESS and DROP_PKT
pkt_drop  output  1  one-cycle pulse when a dropped packet ends (feature only, else tied 0)

Behaviour:
- Reset (resetn low, asynchronous):
  - State goes to DECODE_ADDRESS and cur_ch to 0.
  - detect_add=1; all other outputs 0.
- All outputs are decoded from registered state or cur_ch (Moore); no combinational path from inputs.
- Address valid means data_in < NUM_CH.
- DECODE_ADDRESS (DA):
  - pkt_valid & valid & fifo_empty[data_in] -> LOAD_FIRST_DATA.
  - pkt_valid & valid & !fifo_empty[data_in] -> WAIT_TILL_EMPTY.
  - cur_ch <= data_in on either exit.
  - pkt_valid & invalid: handled per Optional Feature.
  - Otherwise stay.
- WAIT_TILL_EMPTY: fifo_empty[cur_ch] -> LOAD_FIRST_DATA, else stay.
- LOAD_FIRST_DATA -> LOAD_DATA unconditionally (1 cycle).
- LOAD_DATA:
  - fifo_full -> FIFO_FULL_STATE.
  - else !pkt_valid -> LOAD_PARITY.
  - else stay.
- FIFO_FULL_STATE: !fifo_full -> LOAD_AFTER_FULL, else stay.
- LOAD_AFTER_FULL:
  - parity_done -> DA.
  - else low_pkt_valid -> LOAD_PARITY.
  - else -> LOAD_DATA.
- LOAD_PARITY -> CHECK_PARITY_ERROR unconditionally.
- CHECK_PARITY_ERROR: fifo_full -> FIFO_FULL_STATE, else -> DA.
- busy:
  - 1 in LOAD_FIRST_DATA, LOAD_PARITY, FIFO_FULL_STATE, LOAD_AFTER_FULL, WAIT_TILL_EMPTY, CHECK_PARITY_ERROR.
  - 0 in DA, LOAD_DATA and DROP_PKT.
- Soft reset:
  - soft_reset[cur_ch]=1 in any state except DA/DROP_PKT -> DA next edge.
  - This has priority over all other transitions.
  - soft_reset on non-selected channels is ignored.
  - In DA, soft_reset is ignored.
- ch_sel = 1<<cur_ch in every state except DA and DROP_PKT.
- Simultaneous fifo_full and !pkt_valid in LOAD_DATA: fifo_full wins.

Optional Feature:
ROUTER_FSM_DROP_EN
- Defined:
  - pkt_valid & invalid address in DA -> DROP_PKT.
  - DROP_PKT: busy=0, write_enb_reg=0, ch_sel=0; stays while pkt_valid=1.
  - pkt_valid=0 -> DA, with pkt_drop=1 for that single cycle (registered, asserted the cycle state returns to DA).
  - The whole packet including parity is consumed without being written.
- Undefined:
  - DROP_PKT state does not exist; pkt_drop is tied 0.
  - Invalid address leaves FSM in DA (detect_add=1, busy=0); bytes are discarded until a valid header is seen.

Test Plan:
- Reset mid-packet: in LOAD_DATA, pull resetn low between edges -> detect_add=1, ld_state=0, busy=0, ch_sel=0 immediately (no clock edge).
- Empty path: data_in=0, fifo_empty=3'b111, pkt_valid=1 for 3 cycles then 0, fifo_full=0:
  - Expect DA -> LFD(busy=1, ch_sel=001) -> LD(write_enb_reg=1) -> LP -> CPE(rst_int_reg=1) -> DA.
- Wait + full: data_in=1, fifo_empty[1]=0 for 2 cycles -> WAIT_TILL_EMPTY (busy=1) -> LFD -> LD.
  - fifo_full=1 -> full_state=1; release -> laf_state=1.
  - low_pkt_valid=1, parity_done=0 -> LP -> CPE.
- LAF loopback: data_in=2, in LAF with parity_done=0, low_pkt_valid=0 -> LOAD_DATA; then pkt_valid=0 -> LP.
  - parity_done=1 in LAF -> DA.
- Soft reset: in WAIT_TILL_EMPTY on ch2, pulse soft_reset=3'b001 -> no change; pulse 3'b100 -> DA next edge.
- Invalid address (NUM_CH=3, data_in=3, 4 valid bytes):
  - With ROUTER_FSM_DROP_EN: busy=0, write_enb_reg=0 throughout, one-cycle pkt_drop=1 at end.
  - Without: detect_add stays 1, pkt_drop=0.
